ocp_arb2: RTL

OCP_ARB2 -- requirements
Module: ocp_arb2

---
 rtl/ocp_arb2_if.sv | 42 ++++
 rtl/ocp_arb2.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ocp_arb2_if.sv
// Bus bundle for the two-master OCP arbiter: both master links plus the shared slave link.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

interface ocp_arb2_if;
   logic [`ADDR_WIDTH-1:0] i_M0Addr, i_M1Addr;
   logic [2:0]             i_M0Cmd, i_M1Cmd;
   logic [`DATA_WIDTH-1:0] i_M0Data, i_M1Data;
   logic [`BEN_WIDTH-1:0]  i_M0ByteEn, i_M1ByteEn;
   logic                   o_S0CmdAccept, o_S1CmdAccept;
   logic [`DATA_WIDTH-1:0] o_S0Data, o_S1Data;
   logic [1:0]             o_S0Resp, o_S1Resp;
   logic [`ADDR_WIDTH-1:0] o_MAddr;
   logic [2:0]             o_MCmd;
   logic [`DATA_WIDTH-1:0] o_MData;
   logic [`BEN_WIDTH-1:0]  o_MByteEn;
   logic                   i_SCmdAccept;
   logic [`DATA_WIDTH-1:0] i_SData;
   logic [1:0]             i_SResp;

   modport slave (
      input  i_M0Addr, i_M1Addr, i_M0Cmd, i_M1Cmd, i_M0Data, i_M1Data,
             i_M0ByteEn, i_M1ByteEn, i_SCmdAccept, i_SData, i_SResp,
      output o_S0CmdAccept, o_S1CmdAccept, o_S0Data, o_S1Data, o_S0Resp, o_S1Resp,
             o_MAddr, o_MCmd, o_MData, o_MByteEn
   );

   modport master (
      output i_M0Addr, i_M1Addr, i_M0Cmd, i_M1Cmd, i_M0Data, i_M1Data,
             i_M0ByteEn, i_M1ByteEn, i_SCmdAccept, i_SData, i_SResp,
      input  o_S0CmdAccept, o_S1CmdAccept, o_S0Data, o_S1Data, o_S0Resp, o_S1Resp,
             o_MAddr, o_MCmd, o_MData, o_MByteEn
   );
endinterface

// File: rtl/ocp_arb2.sv
// Two-master OCP arbiter: round-robin grant, one transaction in flight, combinational
// pass-through while granted, and a cycle budget that aborts a stuck slave with ERR.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'd0
`define OCP_CMD_WRITE 3'd1
`define OCP_CMD_READ  3'd2
`define OCP_RESP_NULL 2'd0
`define OCP_RESP_DVA  2'd1
`define OCP_RESP_ERR  2'd3
`endif

module ocp_arb2 #(
   parameter int TIMEOUT = 16
) (
   input  logic      clk,
   input  logic      nrst,
   ocp_arb2_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_gnt;
   logic       r_lst;
   logic [7:0] r_cnt;

   logic                   w_req0, w_req1;
   logic [2:0]             w_cmd;
   logic [`ADDR_WIDTH-1:0] w_addr;
   logic [`DATA_WIDTH-1:0] w_data;
   logic [`BEN_WIDTH-1:0]  w_ben;
   logic                   w_svld, w_drop, w_done, w_tmo;
   logic                   w_acc;
   logic [1:0]             w_resp;
   logic [`DATA_WIDTH-1:0] w_rdata;

   assign w_req0 = (bus.i_M0Cmd != `OCP_CMD_IDLE);
   assign w_req1 = (bus.i_M1Cmd != `OCP_CMD_IDLE);
   assign w_cmd  = r_gnt ? bus.i_M1Cmd    : bus.i_M0Cmd;
   assign w_addr = r_gnt ? bus.i_M1Addr   : bus.i_M0Addr;
   assign w_data = r_gnt ? bus.i_M1Data   : bus.i_M0Data;
   assign w_ben  = r_gnt ? bus.i_M1ByteEn : bus.i_M0ByteEn;
   assign w_svld = (bus.i_SResp != `OCP_RESP_NULL);

   // A withdrawn request beats both completion and timeout, and leaves lst alone.
   assign w_drop = (r_state == CMD) && (w_cmd == `OCP_CMD_IDLE);
   assign w_done = (r_state == CMD)
                 ? (!w_drop && bus.i_SCmdAccept && (w_cmd == `OCP_CMD_WRITE || w_svld))
                 : (r_state == RESP) && w_svld;
   assign w_tmo  = (r_state != IDLE) && !w_drop && !w_done && (r_cnt == LAST_CNT);

   always_comb begin
      bus.o_MCmd    = `OCP_CMD_IDLE;
      bus.o_MAddr   = '0;
      bus.o_MData   = '0;
      bus.o_MByteEn = '0;
      w_acc         = 1'b0;
      w_resp        = `OCP_RESP_NULL;
      w_rdata       = '0;
      if (r_state == CMD) begin
         bus.o_MCmd    = w_tmo ? `OCP_CMD_IDLE : w_cmd;
         bus.o_MAddr   = w_addr;
         bus.o_MData   = w_data;
         bus.o_MByteEn = w_ben;
         w_acc         = w_tmo ? 1'b1 : bus.i_SCmdAccept;
         w_resp        = w_tmo ? `OCP_RESP_ERR : bus.i_SResp;
         w_rdata       = w_tmo ? '0 : bus.i_SData;
      end else if (r_state == RESP) begin
         w_resp  = w_tmo ? `OCP_RESP_ERR : bus.i_SResp;
         w_rdata = w_svld ? bus.i_SData : '0;
      end
   end

   // Only the granted master ever sees slave-side activity.
   assign bus.o_S0CmdAccept = !r_gnt && w_acc;
   assign bus.o_S0Resp      = r_gnt ? `OCP_RESP_NULL : w_resp;
   assign bus.o_S0Data      = r_gnt ? '0 : w_rdata;
   assign bus.o_S1CmdAccept = r_gnt && w_acc;
   assign bus.o_S1Resp      = r_gnt ? w_resp : `OCP_RESP_NULL;
   assign bus.o_S1Data      = r_gnt ? w_rdata : '0;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_gnt   <= 1'b0;
         r_lst   <= 1'b1;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req0 || w_req1) begin
                  r_gnt   <= (w_req0 && w_req1) ? ~r_lst : w_req1;
                  r_cnt   <= '0;
                  r_state <= CMD;
               end
            end
            CMD, RESP: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_drop) begin
                  r_state <= IDLE;
               end else if (w_done || w_tmo) begin
                  r_lst   <= r_gnt;
                  r_state <= IDLE;
               end else if (r_state == CMD && bus.i_SCmdAccept) begin
                  r_state <= RESP;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
